// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage RV32I pipeline
//            (memory freeze > redirect > load-use). Optional macro
//            HAZ_PERF_CNT_EN adds saturating performance counters.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_ReadRegNum1,
    input  logic [4:0]       ID_ReadRegNum2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             EX_cntl_MemRead,
    input  logic [4:0]       EX_WriteRegNum,
    input  logic             EX_redirect,
    input  logic             MEM_dmem_req,
    input  logic             MEM_dmem_ready,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             IF_IDFlush,
    output logic             ID_EXWrite,
    output logic             ID_EXFlush,
    output logic             EX_MEMWrite,
    output logic             MEM_WBFlush,
    output logic             sel_PCRedirect,
    output logic             busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_freeze_cnt,
    output logic [CNT_W-1:0] perf_loaduse_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15) || (CNT_W < 1)) begin : g_param_check
        $error("pipeline_hazard_ctrl: FLUSH_CYCLES must be 1..15 and CNT_W >= 1");
    end

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       freeze;
    logic       loaduse;
    logic       lu_stall;

    assign freeze  = MEM_dmem_req && !MEM_dmem_ready;
    assign loaduse = EX_cntl_MemRead && (EX_WriteRegNum != 5'd0) &&
                     ((ID_use_rs1 && (ID_ReadRegNum1 == EX_WriteRegNum)) ||
                      (ID_use_rs2 && (ID_ReadRegNum2 == EX_WriteRegNum)));
    assign busy    = (state_q != ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        PCWrite        = 1'b1;
        IF_IDWrite     = 1'b1;
        IF_IDFlush     = 1'b0;
        ID_EXWrite     = 1'b1;
        ID_EXFlush     = 1'b0;
        EX_MEMWrite    = 1'b1;
        MEM_WBFlush    = 1'b0;
        sel_PCRedirect = 1'b0;
        lu_stall       = 1'b0;
        if (reset) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMWrite = 1'b0;
            IF_IDFlush  = 1'b1;
            ID_EXFlush  = 1'b1;
            MEM_WBFlush = 1'b1;
        end else if (freeze) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMWrite = 1'b0;
            MEM_WBFlush = 1'b1;
            if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
            end
        end else if (state_q == ST_REDIRECT) begin
            // ID/EX already hold bubbles; only the fetch side keeps flushing
            IF_IDFlush = 1'b1;
            cnt_d      = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                state_d = ST_RUN;
            end
        end else begin
            // RUN, or the cycle MEM_WAIT completes, which behaves as RUN
            state_d = ST_RUN;
            if (EX_redirect) begin
                sel_PCRedirect = 1'b1;
                IF_IDFlush     = 1'b1;
                ID_EXFlush     = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    cnt_d   = 4'(FLUSH_CYCLES - 1);
                    state_d = ST_REDIRECT;
                end
            end else if (loaduse) begin
                PCWrite    = 1'b0;
                IF_IDWrite = 1'b0;
                ID_EXFlush = 1'b1;
                lu_stall   = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] frz_cnt_q, lu_cnt_q, fl_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frz_cnt_q <= '0;
            lu_cnt_q  <= '0;
            fl_cnt_q  <= '0;
        end else begin
            if (freeze && (frz_cnt_q != C_CNT_MAX)) frz_cnt_q <= frz_cnt_q + C_CNT_ONE;
            if (lu_stall && (lu_cnt_q != C_CNT_MAX)) lu_cnt_q <= lu_cnt_q + C_CNT_ONE;
            if (IF_IDFlush && (fl_cnt_q != C_CNT_MAX)) fl_cnt_q <= fl_cnt_q + C_CNT_ONE;
        end
    end

    assign perf_freeze_cnt  = frz_cnt_q;
    assign perf_loaduse_cnt = lu_cnt_q;
    assign perf_flush_cnt   = fl_cnt_q;
`else
    logic unused_lu_stall;
    assign unused_lu_stall = lu_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3)
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int C_CNT_W = 16;

    // Output vector: {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
    //                 EX_MEMWrite, MEM_WBFlush, sel_PCRedirect, busy}
    localparam logic [8:0] C_DEF      = 9'b110101000;
    localparam logic [8:0] C_DEF_BUSY = 9'b110101001;
    localparam logic [8:0] C_RST      = 9'b001010100;
    localparam logic [8:0] C_RST_BUSY = 9'b001010101;
    localparam logic [8:0] C_LU       = 9'b000111000;
    localparam logic [8:0] C_FRZ      = 9'b000000100;
    localparam logic [8:0] C_FRZ_BUSY = 9'b000000101;
    localparam logic [8:0] C_RED      = 9'b111111010;
    localparam logic [8:0] C_RED_BUSY = 9'b111111011;
    localparam logic [8:0] C_REDIR    = 9'b111101001;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_ReadRegNum1, ID_ReadRegNum2, EX_WriteRegNum;
    logic       ID_use_rs1, ID_use_rs2, EX_cntl_MemRead, EX_redirect;
    logic       MEM_dmem_req, MEM_dmem_ready;
    logic       PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush;
    logic       EX_MEMWrite, MEM_WBFlush, sel_PCRedirect, busy;
`ifdef HAZ_PERF_CNT_EN
    logic [C_CNT_W-1:0] perf_freeze_cnt, perf_loaduse_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (3),
        .CNT_W        (C_CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_ReadRegNum1  (ID_ReadRegNum1),
        .ID_ReadRegNum2  (ID_ReadRegNum2),
        .ID_use_rs1      (ID_use_rs1),
        .ID_use_rs2      (ID_use_rs2),
        .EX_cntl_MemRead (EX_cntl_MemRead),
        .EX_WriteRegNum  (EX_WriteRegNum),
        .EX_redirect     (EX_redirect),
        .MEM_dmem_req    (MEM_dmem_req),
        .MEM_dmem_ready  (MEM_dmem_ready),
        .PCWrite         (PCWrite),
        .IF_IDWrite      (IF_IDWrite),
        .IF_IDFlush      (IF_IDFlush),
        .ID_EXWrite      (ID_EXWrite),
        .ID_EXFlush      (ID_EXFlush),
        .EX_MEMWrite     (EX_MEMWrite),
        .MEM_WBFlush     (MEM_WBFlush),
        .sel_PCRedirect  (sel_PCRedirect),
        .busy            (busy)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_freeze_cnt  (perf_freeze_cnt),
        .perf_loaduse_cnt (perf_loaduse_cnt),
        .perf_flush_cnt   (perf_flush_cnt)
`endif
    );

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic redir, input logic req, input logic rdy);
        EX_cntl_MemRead = mr;
        EX_WriteRegNum  = rd;
        ID_ReadRegNum1  = rs1;
        ID_ReadRegNum2  = rs2;
        ID_use_rs1      = u1;
        ID_use_rs2      = u2;
        EX_redirect     = redir;
        MEM_dmem_req    = req;
        MEM_dmem_ready  = rdy;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        #1;
        obs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
               EX_MEMWrite, MEM_WBFlush, sel_PCRedirect, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_forced", C_RST);
        reset = 1'b0;
        chk("idle_defaults", C_DEF);
        nxt();

        // Load-use through rs2, then clears once the load leaves EX
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse_rs2", C_LU);
        nxt();
        set_in(1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse_after", C_DEF);
        nxt();

        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("x0_no_stall", C_DEF);
        nxt();
        set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("unused_rs1_no_stall", C_DEF);
        nxt();
        set_in(1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse_rs1", C_LU);
        nxt();
        set_in(1'b0, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("non_load_no_stall", C_DEF);
        nxt();

        // Memory wait: three frozen cycles, then the ready cycle
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("memwait_c1", C_FRZ);
        nxt();
        chk("memwait_c2", C_FRZ_BUSY);
        nxt();
        chk("memwait_c3", C_FRZ_BUSY);
        nxt();
        MEM_dmem_ready = 1'b1;
        chk("memwait_ready", C_DEF_BUSY);
        nxt();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("memwait_back_run", C_DEF);
        nxt();

        // Redirect with a three-cycle fetch flush
        EX_redirect = 1'b1;
        chk("redirect_c0", C_RED);
        nxt();
        EX_redirect = 1'b0;
        chk("redirect_c1", C_REDIR);
        nxt();
        chk("redirect_c2", C_REDIR);
        nxt();
        chk("redirect_c3_defaults", C_DEF);
        nxt();

        // Redirect + load-use + freeze together
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("simul_frz1", C_FRZ);
        nxt();
        chk("simul_frz2", C_FRZ_BUSY);
        nxt();
        MEM_dmem_ready = 1'b1;
        chk("simul_ready_redirect", C_RED_BUSY);
        nxt();
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("simul_redir_ignores", C_REDIR);
        nxt();
        // Freeze in REDIRECT holds the counter and stays busy
        MEM_dmem_req = 1'b1;
        chk("redir_frozen", C_FRZ_BUSY);
        nxt();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("redir_resume", C_REDIR);
        nxt();
        chk("simul_back_run", C_DEF);
        nxt();

        // Reset while the flush counter is at one
        EX_redirect = 1'b1;
        chk("rst_redirect_c0", C_RED);
        nxt();
        EX_redirect = 1'b0;
        chk("rst_redirect_c1", C_REDIR);
        nxt();
        reset = 1'b1;
        chk("rst_in_redirect", C_RST_BUSY);
        nxt();
        reset = 1'b0;
        chk("rst_after_release", C_DEF);
`ifdef HAZ_PERF_CNT_EN
        checks++;
        assert ({perf_freeze_cnt, perf_loaduse_cnt, perf_flush_cnt} === {(3*C_CNT_W){1'b0}}) else begin
            errors++;
            $error("FAIL perf_cleared observed=%0d/%0d/%0d expected=0/0/0",
                   perf_freeze_cnt, perf_loaduse_cnt, perf_flush_cnt);
        end
`endif
        nxt();
        chk("rst_stays_run", C_DEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives write-enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Handles three hazards in fixed priority: data-memory wait (freeze), taken branch/jump (redirect + multi-cycle fetch flush), load-use (one-cycle bubble).

Parameters:
- FLUSH_CYCLES, 1, cycles IF_ID is flushed after a redirect (1..15; covers fetch latency).
- CNT_W, 16, width of optional performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ID_ReadRegNum1  in  5  rs1 of the instruction in ID.
- ID_ReadRegNum2  in  5  rs2 of the instruction in ID.
- ID_use_rs1  in  1  ID instruction reads rs1.
- ID_use_rs2  in  1  ID instruction reads rs2.
- EX_cntl_MemRead  in  1  instruction in EX is a load.
- EX_WriteRegNum  in  5  rd of the instruction in EX.
- EX_redirect  in  1  taken branch or jump resolved in EX.
- MEM_dmem_req  in  1  MEM stage has an active load/store.
- MEM_dmem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_IDWrite  out  1  IF_ID load enable.
- IF_IDFlush  out  1  IF_ID loads a bubble.
- ID_EXWrite  out  1  ID_EX load enable.
- ID_EXFlush  out  1  ID_EX loads a bubble.
- EX_MEMWrite  out  1  EX_MEM load enable.
- MEM_WBFlush  out  1  MEM_WB loads a bubble.
- sel_PCRedirect  out  1  PC mux selects the EX branch target.
- busy  out  1  state != RUN.

Behaviour:
- Outputs are combinational from state and inputs. State, counter and optional counters are registered.
- Defaults: all Write = 1, all Flush = 0, sel_PCRedirect = 0.
- While reset = 1, outputs are forced to Write = 0, IF_IDFlush = ID_EXFlush = MEM_WBFlush = 1, sel_PCRedirect = 0.
- On the reset edge: state = RUN, flush counter = 0, perf counters = 0.
- States: RUN, MEM_WAIT, REDIRECT.
- freeze = MEM_dmem_req && !MEM_dmem_ready.
- loaduse = EX_cntl_MemRead && EX_WriteRegNum != 0 && ((ID_use_rs1 && ID_ReadRegNum1 == EX_WriteRegNum) || (ID_use_rs2 && ID_ReadRegNum2 == EX_WriteRegNum)).
- Priority 1, freeze (any state):
  - PCWrite = IF_IDWrite = ID_EXWrite = EX_MEMWrite = 0, MEM_WBFlush = 1.
  - All other flushes = 0; flush counter holds.
  - From RUN: next state = MEM_WAIT.
  - From REDIRECT: state stays REDIRECT.
- MEM_WAIT:
  - Leaves on the first cycle MEM_dmem_ready = 1. That cycle behaves as RUN (redirect and loaduse are evaluated).
  - Next state is RUN, or REDIRECT if a redirect fires with FLUSH_CYCLES > 1.
- Priority 2, EX_redirect with no freeze, in RUN or on the MEM_WAIT exit cycle:
  - sel_PCRedirect = 1, PCWrite = 1, IF_IDFlush = 1, ID_EXFlush = 1. loaduse is ignored.
  - If FLUSH_CYCLES > 1: counter = FLUSH_CYCLES-1, next state = REDIRECT.
- REDIRECT, not frozen:
  - IF_IDFlush = 1, PCWrite = 1. loaduse and EX_redirect are ignored (ID/EX hold bubbles).
  - Counter decrements each cycle; when it reaches 0, next state = RUN.
- Priority 3, loaduse in RUN:
  - PCWrite = 0, IF_IDWrite = 0, ID_EXFlush = 1, for exactly one cycle.
  - No state change; the next cycle the load is in MEM and the hazard clears naturally.
- x0 never causes a stall.
- A reset asserted mid-wait or mid-redirect aborts it immediately. No pending redirect survives reset.
- busy = (state != RUN).

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_freeze_cnt, perf_loaduse_cnt and perf_flush_cnt, each CNT_W wide.
  - They count cycles of freeze, applied loaduse stall, and IF_IDFlush = 1 respectively.
  - Saturate at all-ones and clear on reset.
- Undefined: the ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: EX load rd = 5, ID rs2 = 5, use_rs2 = 1 -> one cycle PCWrite = 0, IF_IDWrite = 0, ID_EXFlush = 1; the next cycle all defaults.
- x0 / unused operand: EX load rd = 0 and ID rs1 = 0; then rd = 7 with rs1 = 7 but use_rs1 = 0 -> no stall either case.
- Memory wait: dmem_req = 1, ready = 0 for 3 cycles, then ready = 1 -> 3 cycles with all Write = 0 and MEM_WBFlush = 1, busy = 1 from cycle 2; cycle 4 defaults, state RUN.
- Redirect, FLUSH_CYCLES = 3: EX_redirect pulse -> cycle 0 sel_PCRedirect = 1, IF_IDFlush = ID_EXFlush = 1; cycles 1-2 IF_IDFlush = 1 only, busy = 1; cycle 3 defaults.
- Simultaneous: EX_redirect + loaduse + freeze held 2 cycles -> freeze outputs both cycles; on the ready cycle redirect wins, with sel_PCRedirect = 1 and no loaduse stall.
- Reset in REDIRECT: assert reset at counter = 1 -> forced reset outputs; after release state RUN, defaults, perf counters = 0 (HAZ_PERF_CNT_EN).
